mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_pick2.sv | 26 ++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master data-port arbiter in front of `mem`.
// State encodings and master IDs are also used by the loader/DMA side.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC0  = 3'd1,
        ACC1  = 3'd2,
        HOLD0 = 3'd3,
        HOLD1 = 3'd4
    } arb_state_t;

    localparam logic M_CPU = 1'b0;   // CPU load/store unit
    localparam logic M_LDR = 1'b1;   // UART boot loader / DMA engine

    // True in the single cycle an access is driven onto the mem port.
    function automatic logic is_acc(arb_state_t s);
        return (s == ACC0) || (s == ACC1);
    endfunction

endpackage

// File: rtl/mem_arbiter_pick2.sv
// Combinational two-way picker used by mem_arbiter in IDLE.
// prio_mode=1 gives master 0 every tie; otherwise ties go to the
// master that did not own the port last.
module arb_pick2
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    input  logic prio_mode,
    output logic valid,
    output logic winner
);

    // Pick a winner among the active requests.
    always_comb begin
        valid  = req0 | req1;
        winner = M_CPU;
        if (req0 && req1) begin
            winner = prio_mode ? M_CPU : ~last_owner;
        end else if (req1) begin
            winner = M_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the data-side port of `mem` between the CPU (master 0) and the
// loader/DMA engine (master 1). Round-robin with a bounded lock for
// read-modify-write sequences. Optional build macro MEM_ARB_CPU_PRIO_EN
// switches IDLE arbitration to fixed priority for master 0.
//
// Handshake: a master raises reqX with stable fields and holds them until it
// sees gntX (a one-cycle pulse in the cycle the access hits mem); it may
// change req/fields only in the cycle after gnt. Reads return rdata with a
// one-cycle rvalidX pulse in the cycle after gnt.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              lock_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = $clog2(MAX_LOCK) + 1;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last_owner;
    logic [CNT_W-1:0]  lock_cnt;

    logic              lat_we;
    logic              lat_lock;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              load_en;
    logic              load_sel;
    logic              in_acc;
    logic              acc_owner;
    logic              lock_last;
    logic              pick_valid;
    logic              pick_winner;
    logic              prio_mode;

`ifdef MEM_ARB_CPU_PRIO_EN
    assign prio_mode = 1'b1;
`else
    assign prio_mode = 1'b0;
`endif

    arb_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner),
        .prio_mode  (prio_mode),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign in_acc    = is_acc(state);
    assign acc_owner = (state == ACC1);
    // This access is the last one the lock budget allows.
    assign lock_last = (lock_cnt == CNT_W'(MAX_LOCK - 1));

    // Next state and request-latch enable.
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        load_sel  = M_CPU;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    load_en   = 1'b1;
                    load_sel  = pick_winner;
                    state_nxt = (pick_winner == M_LDR) ? ACC1 : ACC0;
                end
            end
            ACC0, ACC1: begin
                if (lat_lock && !lock_last) begin
                    state_nxt = acc_owner ? HOLD1 : HOLD0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HOLD0: begin
                if (req0) begin
                    load_en   = 1'b1;
                    load_sel  = M_CPU;
                    state_nxt = ACC0;
                end
            end
            HOLD1: begin
                if (req1) begin
                    load_en   = 1'b1;
                    load_sel  = M_LDR;
                    state_nxt = ACC1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, round-robin history and lock budget counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= M_LDR;
            lock_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (in_acc) begin
                last_owner <= acc_owner;
                if (!lat_lock || lock_last) begin
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Capture the winning master's request fields when it is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_lock  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (load_en) begin
            lat_we    <= load_sel ? we1    : we0;
            lat_lock  <= load_sel ? lock1  : lock0;
            lat_addr  <= load_sel ? addr1  : addr0;
            lat_wdata <= load_sel ? wdata1 : wdata0;
        end
    end

    // Registered read response and forced-release pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata    <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            lock_err <= 1'b0;
        end else begin
            rvalid0  <= (state == ACC0) && !lat_we;
            rvalid1  <= (state == ACC1) && !lat_we;
            lock_err <= in_acc && lat_lock && lock_last;
            if (in_acc && !lat_we) begin
                rdata <= mem_rdata;
            end
        end
    end

    // mem port follows the latched request; address/data hold between accesses.
    assign gnt0      = (state == ACC0);
    assign gnt1      = (state == ACC1);
    assign mem_we    = in_acc && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign dbg_state = state;

endmodule
